alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin two-port arbiter sharing one combinational 32-bit ALU,
//            with a one-entry registered response channel tagged by requester.
//            Optional feature macro: ALU_ARB_ILLEGAL_OP_EN (illegal-opcode trap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_aluc,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_aluc,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  input  logic        alu_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q,    rsp_id_d;
  logic [31:0] rsp_data_q,  rsp_data_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        last_q,      last_d;

  logic        w_can_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_grant_any;
  logic        w_accept;
  logic [3:0]  w_sel_aluc;
  logic [31:0] w_sel_src1;
  logic [31:0] w_sel_src2;
  logic        w_illegal;

  assign w_can_accept = !rsp_valid_q | rsp_ready;

  // last_q=1 means req1 was served last, so req0 wins a tie (and vice versa)
  assign w_grant0    = !rst & req0_valid & (!req1_valid | last_q);
  assign w_grant1    = !rst & req1_valid & (!req0_valid | !last_q);
  assign w_grant_any = w_grant0 | w_grant1;

  assign req0_ready = w_grant0 & w_can_accept;
  assign req1_ready = w_grant1 & w_can_accept;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_aluc = w_grant1 ? req1_aluc : (w_grant0 ? req0_aluc : 4'd0);
  assign w_sel_src1 = w_grant1 ? req1_src1 : (w_grant0 ? req0_src1 : 32'd0);
  assign w_sel_src2 = w_grant1 ? req1_src2 : (w_grant0 ? req0_src2 : 32'd0);

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign w_illegal = w_grant_any & (w_sel_aluc > 4'd9);
`else
  assign w_illegal = 1'b0;
`endif

  assign alu_aluc = w_illegal ? 4'd0  : w_sel_aluc;
  assign alu_src1 = w_illegal ? 32'd0 : w_sel_src1;
  assign alu_src2 = w_illegal ? 32'd0 : w_sel_src2;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    last_d      = last_q;
    if (w_accept) begin
      // A fresh accept overwrites any response draining this same cycle
      rsp_valid_d = 1'b1;
      rsp_id_d    = req1_ready;
      rsp_data_d  = w_illegal ? 32'd0 : alu_out;
      rsp_flags_d = w_illegal ? 4'b0001
                              : {alu_sign, alu_overflow, alu_cout, alu_zero};
      rsp_err_d   = w_illegal;
      last_d      = req1_ready;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_flags_q <= 4'd0;
      rsp_err_q   <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_aluc, req1_aluc;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_out;
  logic        alu_zero, alu_cout, alu_overflow, alu_sign;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;

  int n_cmp;
  int n_bad;

  alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_aluc    (req0_aluc),
    .req0_src1    (req0_src1),
    .req0_src2    (req0_src2),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_aluc    (req1_aluc),
    .req1_src1    (req1_src1),
    .req1_src2    (req1_src2),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_aluc     (alu_aluc),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_sign     (alu_sign),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes yield a recognisable pattern
  logic [32:0] w_sum;
  always_comb begin
    w_sum        = 33'd0;
    alu_out      = 32'hDEADBEEF;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      4'd0: begin
        w_sum        = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_out      = w_sum[31:0];
        alu_cout     = w_sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_out[31] != alu_src1[31]);
      end
      4'd1: begin
        alu_out      = alu_src1 - alu_src2;
        alu_cout     = alu_src1 < alu_src2;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_out[31] != alu_src1[31]);
      end
      4'd2: alu_out = alu_src1 & alu_src2;
      4'd3: alu_out = alu_src1 | alu_src2;
      4'd4: alu_out = alu_src1 ^ alu_src2;
      4'd5: alu_out = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      4'd6: alu_out = {31'd0, alu_src1 < alu_src2};
      4'd7: alu_out = alu_src1 << alu_src2[4:0];
      4'd8: alu_out = alu_src1 >> alu_src2[4:0];
      4'd9: alu_out = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
      default: alu_out = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_sign = alu_out[31];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_aluc = op; req0_src1 = a; req0_src2 = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_aluc = op; req1_src1 = a; req1_src2 = b;
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [31:0] data, input logic [3:0] flags);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    check({tag, "_data"},  rsp_data,           data);
    check({tag, "_flags"}, {28'd0, rsp_flags}, {28'd0, flags});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    rsp_ready = 1'b0;
    set0(1'b1, 4'd0, 32'h11111111, 32'h22222222);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); tick();

    // Reset state: outputs idle even with a request present
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_alu_src1",  alu_src1, 32'd0);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;
    tick();

    // Single ADD with carry-out wrapping to zero
    rsp_ready = 1'b1;
    set0(1'b1, 4'd0, 32'hFFFFFFFF, 32'h00000001);
    #1;
    check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("add_alu_src1", alu_src1, 32'hFFFFFFFF);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    check_rsp("add", 1'b0, 32'h00000000, 4'b0011);
    tick();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // SUB signed overflow from req1
    set1(1'b1, 4'd1, 32'h80000000, 32'h00000001);
    tick();
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    check_rsp("sub", 1'b1, 32'h7FFFFFFF, 4'b0100);

    // Contention: strict alternation starting with req0, back-to-back
    set0(1'b1, 4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F);
    set1(1'b1, 4'd4, 32'h12345678, 32'h12345678);
    #1;
    check("cont0_r0", {31'd0, req0_ready}, 32'd1);
    check("cont0_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    check_rsp("cont0", 1'b0, 32'hFFFFFFFF, 4'b1000);
    set0(1'b1, 4'd4, 32'hAAAA0000, 32'h0000AAAA);
    #1;
    check("cont1_r1", {31'd0, req1_ready}, 32'd1);
    check("cont1_r0", {31'd0, req0_ready}, 32'd0);
    tick();
    check_rsp("cont1", 1'b1, 32'h00000000, 4'b0001);
    set1(1'b1, 4'd4, 32'h00000001, 32'h00000003);
    tick();
    check_rsp("cont2", 1'b0, 32'hAAAAAAAA, 4'b1000);
    tick();
    check_rsp("cont3", 1'b1, 32'h00000002, 4'b0000);

    // Backpressure: response frozen, no grants accepted, pointer not moving
    rsp_ready = 1'b0;
    set0(1'b1, 4'd2, 32'hFF00FF00, 32'h0FF00FF0);
    set1(1'b1, 4'd3, 32'h80000000, 32'h00000001);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_r0", {31'd0, req0_ready}, 32'd0);
      check("bp_r1", {31'd0, req1_ready}, 32'd0);
      check_rsp("bp_hold", 1'b1, 32'h00000002, 4'b0000);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_r0", {31'd0, req0_ready}, 32'd1);
    tick();
    check_rsp("bp_new", 1'b0, 32'h0F000F00, 4'b0000);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("bp_next_r1", {31'd0, req1_ready}, 32'd1);
    tick();
    check_rsp("bp_or", 1'b1, 32'h80000001, 4'b1000);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Illegal opcode on req0
    set0(1'b1, 4'b1100, 32'h00000005, 32'h00000006);
    #1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check("ill_alu_aluc", {28'd0, alu_aluc}, 32'd0);
    check("ill_alu_src1", alu_src1, 32'd0);
`else
    check("ill_alu_aluc", {28'd0, alu_aluc}, 32'd12);
    check("ill_alu_src1", alu_src1, 32'd5);
`endif
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check_rsp("ill", 1'b0, 32'h00000000, 4'b0001);
    check("ill_err", {31'd0, rsp_err}, 32'd1);
`else
    check_rsp("ill", 1'b0, 32'hDEADBEEF, 4'b1000);
    check("ill_err", {31'd0, rsp_err}, 32'd0);
`endif

    // Pointer rotated on that accept: req1 now wins contention
    set0(1'b1, 4'd0, 32'h00000003, 32'h00000004);
    set1(1'b1, 4'd0, 32'h00000010, 32'h00000020);
    #1;
    check("rot_r1", {31'd0, req1_ready}, 32'd1);
    check("rot_r0", {31'd0, req0_ready}, 32'd0);
    tick();
    check_rsp("rot", 1'b1, 32'h00000030, 4'b0000);

    // Asynchronous reset mid-operation, then re-arbitration from reset state
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_id",    {31'd0, rsp_id}, 32'd0);
    check("arst_data",  rsp_data, 32'd0);
    check("arst_r1",    {31'd0, req1_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_r0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    check_rsp("post_rst", 1'b0, 32'h00000007, 4'b0000);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
